// File: rtl/serial_subtractor_pkg.sv
// rtl/serial_subtractor_pkg.sv - shared types and constants for the bit-serial subtractor
package serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // Sequencer state encoding; kept as plain constants so older blocks can reuse the codes
    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t SHIFT = 2'd1;
    localparam state_t DONE  = 2'd2;

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - combinational 1-bit full subtractor cell
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference bit and borrow-out for x - y - bin
    always_comb begin
        d    = x ^ y ^ bin;
        bout = (~x & y) | (~(x ^ y) & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial unsigned subtractor with start/done handshake
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int               CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             cell_d;
    logic             cell_bout;

    // Single cell shared by every bit position; operands arrive LSB first
    full_subtractor u_cell (
        .x    (a_sr[0]),
        .y    (b_sr[0]),
        .bin  (br),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // Status flags decode straight from the state register
    always_comb begin
        busy = (state == SHIFT);
        done = (state == DONE);
    end

    // Sequencer, shift datapath and held result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            a_sr       <= '0;
            b_sr       <= '0;
            res        <= '0;
            cnt        <= '0;
            br         <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        br    <= 1'b0;
                        cnt   <= '0;
                        state <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    br   <= cell_bout;
                    res  <= {cell_d, res[WIDTH-1:1]};
                    if (cnt == LAST) begin
                        // Last bit lands in the outputs on the same edge it is computed
                        diff       <= {cell_d, res[WIDTH-1:1]};
                        borrow_out <= cell_bout;
                        state      <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       borrow_out;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0] va;
        logic [7:0] vb;
        logic [7:0] exp_diff;
        logic       exp_borrow;
    } vec_t;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: unsigned subtraction with a ninth bit catching the borrow
    function automatic logic [8:0] model(input logic [7:0] ma, input logic [7:0] mb);
        return {1'b0, ma} - {1'b0, mb};
    endfunction

    // Launch one operation and return with the bench sitting in the done cycle
    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_in,
                         output int lat, output int nbusy);
        a     = ta;
        b     = tb_in;
        start = 1'b1;
        step();
        start = 1'b0;
        lat   = -1;
        nbusy = 0;
        for (int k = 1; k <= 20 && lat < 0; k++) begin
            if (busy) nbusy++;
            if (done) lat = k;
            else step();
        end
    endtask

    initial begin
        vec_t       vecs[6];
        int         lat;
        int         nbusy;
        int         ndone;
        int         done_cyc[$];
        logic [7:0] got_diff;
        logic [7:0] ra;
        logic [7:0] rb;
        logic [8:0] m;

        vecs[0] = '{8'd5,   8'd3,   8'h02, 1'b0};
        vecs[1] = '{8'd3,   8'd5,   8'hFE, 1'b1};
        vecs[2] = '{8'h00,  8'h01,  8'hFF, 1'b1};
        vecs[3] = '{8'hFF,  8'hFF,  8'h00, 1'b0};
        vecs[4] = '{8'hFF,  8'h00,  8'hFF, 1'b0};
        vecs[5] = '{8'h00,  8'h00,  8'h00, 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        step();
        step();
        check("reset_busy",   busy, 0);
        check("reset_done",   done, 0);
        check("reset_diff",   diff, 0);
        check("reset_borrow", borrow_out, 0);
        rst_n = 1'b1;
        step();

        // Fixed vectors
        foreach (vecs[i]) begin
            do_op(vecs[i].va, vecs[i].vb, lat, nbusy);
            check($sformatf("vec%0d_latency", i), lat, 9);
            check($sformatf("vec%0d_busy_cycles", i), nbusy, 8);
            check($sformatf("vec%0d_diff", i), diff, vecs[i].exp_diff);
            check($sformatf("vec%0d_borrow", i), borrow_out, vecs[i].exp_borrow);
            step();
            check($sformatf("vec%0d_single_pulse", i), done, 0);
        end

        // Result holds through idle
        step();
        step();
        step();
        check("hold_idle_diff", diff, 8'h00);
        check("hold_idle_busy", busy, 0);

        // Randomized operands against the arithmetic model
        for (int r = 0; r < 40; r++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            m  = model(ra, rb);
            do_op(ra, rb, lat, nbusy);
            check($sformatf("rand%0d_latency", r), lat, 9);
            check($sformatf("rand%0d_diff", r), diff, m[7:0]);
            check($sformatf("rand%0d_borrow", r), borrow_out, m[8]);
            step();
            if ($urandom_range(0, 1) == 1) step();
        end

        // Start while busy is ignored; operand changes mid-shift have no effect
        a     = 8'd9;
        b     = 8'd4;
        start = 1'b1;
        step();
        start    = 1'b0;
        ndone    = 0;
        got_diff = 8'hxx;
        for (int k = 1; k <= 25; k++) begin
            if (k == 4) begin
                start = 1'b1;
                a     = 8'd1;
                b     = 8'd2;
            end else if (k == 5) begin
                start = 1'b0;
            end
            if (done) begin
                ndone++;
                got_diff = diff;
            end
            step();
        end
        check("busy_start_done_count", ndone, 1);
        check("busy_start_diff", got_diff, 8'h05);
        check("busy_start_idle", busy, 0);

        // Back-to-back with start held high
        a     = 8'd10;
        b     = 8'd1;
        start = 1'b1;
        step();
        done_cyc.delete();
        for (int k = 1; k <= 30 && done_cyc.size() < 3; k++) begin
            if (k == 13) begin
                check("b2b_hold_diff_in_shift", diff, 8'h09);
                check("b2b_busy_second", busy, 1);
            end
            if (done) begin
                done_cyc.push_back(k);
                check($sformatf("b2b_diff_%0d", done_cyc.size()), diff, 8'h09);
                if (done_cyc.size() == 3) start = 1'b0;
            end
            step();
        end
        check("b2b_done_count", done_cyc.size(), 3);
        if (done_cyc.size() == 3) begin
            check("b2b_done1", done_cyc[0], 9);
            check("b2b_done2", done_cyc[1], 18);
            check("b2b_done3", done_cyc[2], 27);
        end
        start = 1'b0;
        step();
        check("b2b_stop_idle", busy, 0);

        // Reset mid-shift discards the operation
        a     = 8'd7;
        b     = 8'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("midrst_busy",   busy, 0);
        check("midrst_done",   done, 0);
        check("midrst_diff",   diff, 0);
        check("midrst_borrow", borrow_out, 0);
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            if (done) ndone++;
            step();
        end
        check("midrst_no_done", ndone, 0);
        do_op(8'd7, 8'd2, lat, nbusy);
        check("midrst_rerun_latency", lat, 9);
        check("midrst_rerun_diff", diff, 8'h05);
        step();

        // Reset wins over a simultaneous start
        a     = 8'd20;
        b     = 8'd3;
        start = 1'b1;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        start = 1'b0;
        check("rst_vs_start_busy", busy, 0);
        check("rst_vs_start_diff", diff, 0);
        step();
        check("rst_vs_start_still_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
